// File: rtl/up_dwn_bounded_counter.sv
// ---------------------------------------------------------------------------
// up_dwn_bounded_counter
//
// Up/down counter with enable, a variable step, programmable inclusive lower
// and upper bounds, and a synchronous parallel load. When a step would pass a
// bound, the counter either wraps to the opposite bound or saturates at the
// bound it crossed. sat_mode selects the behaviour and may change every cycle.
// A crossing produces a one-cycle terminal-count pulse (tc) and sets a sticky
// overflow (ovf) or underflow (udf) flag.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   en         count enable
//   up_dn      1 = count up, 0 = count down
//   step       increment/decrement amount; 0 = hold
//   load       synchronous parallel load strobe (highest priority)
//   load_val   value loaded when load=1; it is not clamped to the bounds
//   min_val    lower bound (inclusive)
//   max_val    upper bound (inclusive)
//   sat_mode   1 = saturate at the bound, 0 = wrap to the opposite bound
//   clr_flags  synchronous clear of ovf/udf (a same-cycle set wins)
//   count      registered counter value
//   tc         registered one-cycle pulse on each bound crossing
//   ovf        sticky: an up-count crossed max_val
//   udf        sticky: a down-count crossed min_val
//   cfg_err    combinational: min_val > max_val (counting is frozen)
// ---------------------------------------------------------------------------
module up_dwn_bounded_counter #(
    parameter int                     CNT_WIDTH  = 8,
    parameter int                     STEP_WIDTH = 4,
    parameter logic [CNT_WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  load_val,
    input  logic [CNT_WIDTH-1:0]  min_val,
    input  logic [CNT_WIDTH-1:0]  max_val,
    input  logic                  sat_mode,
    input  logic                  clr_flags,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  udf,
    output logic                  cfg_err
);

    // Crossing tests run one bit wider than the widest operand, so neither
    // count+step nor min_val+step can wrap silently.
    localparam int EW = ((CNT_WIDTH > STEP_WIDTH) ? CNT_WIDTH : STEP_WIDTH) + 1;

    logic [EW-1:0]        cnt_x;
    logic [EW-1:0]        step_x;
    logic [EW-1:0]        min_x;
    logic [EW-1:0]        max_x;
    logic                 up_cross;
    logic                 dn_cross;
    logic [CNT_WIDTH-1:0] step_c;

    logic [CNT_WIDTH-1:0] count_d;
    logic                 tc_d;
    logic                 set_ovf;
    logic                 set_udf;

    assign cfg_err = (min_val > max_val);

    assign cnt_x  = {{(EW-CNT_WIDTH){1'b0}}, count};
    assign step_x = {{(EW-STEP_WIDTH){1'b0}}, step};
    assign min_x  = {{(EW-CNT_WIDTH){1'b0}}, min_val};
    assign max_x  = {{(EW-CNT_WIDTH){1'b0}}, max_val};

    // Up: count+step > max. Down: count-step < min, written as
    // count < min+step so that stepping below zero is caught too.
    assign up_cross = (cnt_x + step_x) > max_x;
    assign dn_cross = cnt_x < (min_x + step_x);

    // The CNT_WIDTH-bit step is used only on non-crossing paths. There,
    // step <= max_val (up) or step <= count (down), so truncation loses nothing.
    assign step_c = CNT_WIDTH'(step);

    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (cfg_err) begin
            count_d = count;
        end else if (en && (step != '0)) begin
            if (up_dn) begin
                if (up_cross) begin
                    count_d = sat_mode ? max_val : min_val;
                    tc_d    = 1'b1;
                    set_ovf = 1'b1;
                end else begin
                    count_d = count + step_c;
                end
            end else begin
                if (dn_cross) begin
                    count_d = sat_mode ? min_val : max_val;
                    tc_d    = 1'b1;
                    set_udf = 1'b1;
                end else begin
                    count_d = count - step_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RST_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            // A flag set in this cycle takes precedence over clr_flags.
            ovf   <= set_ovf | (ovf & ~clr_flags);
            udf   <= set_udf | (udf & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_up_dwn_bounded_counter.sv
module tb_up_dwn_bounded_counter;

    localparam int CW = 8;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          up_dn;
    logic [SW-1:0] step;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] min_val;
    logic [CW-1:0] max_val;
    logic          sat_mode;
    logic          clr_flags;
    logic [CW-1:0] count;
    logic          tc;
    logic          ovf;
    logic          udf;
    logic          cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    up_dwn_bounded_counter #(
        .CNT_WIDTH (CW),
        .STEP_WIDTH(SW),
        .RST_VAL   (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .min_val  (min_val),
        .max_val  (max_val),
        .sat_mode (sat_mode),
        .clr_flags(clr_flags),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .udf      (udf),
        .cfg_err  (cfg_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge. The bench samples and drives 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Parallel load of a value. clr_flags may be requested in the same cycle.
    task automatic drive_load(input logic [CW-1:0] v, input logic clr);
        load      = 1'b1;
        load_val  = v;
        en        = 1'b0;
        clr_flags = clr;
        tick();
        load      = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic set_count(input logic u, input logic [SW-1:0] s, input logic sat);
        en       = 1'b1;
        up_dn    = u;
        step     = s;
        sat_mode = sat;
    endtask

    task automatic test_reset();
        // Set ovf by saturating at 255, then load 0x37. The load leaves ovf set.
        min_val = 8'd0; max_val = 8'd255;
        drive_load(8'd255, 1'b0);
        set_count(1'b1, 4'd1, 1'b1);
        tick();
        en = 1'b0;
        drive_load(8'h37, 1'b0);
        n_checks++; if (count !== 8'h37 || ovf !== 1'b1) begin
            $display("FAIL pre_reset: count=%h ovf=%b want 37/1", count, ovf); n_fail++; end
        // Assert the asynchronous reset between clock edges.
        #2 rst = 1'b0;
        #1;
        n_checks++; if (count !== 8'h00) begin
            $display("FAIL reset_count: got %h want 00", count); n_fail++; end
        n_checks++; if ({tc, ovf, udf} !== 3'b000) begin
            $display("FAIL reset_flags: tc/ovf/udf=%b want 000", {tc, ovf, udf}); n_fail++; end
        tick();
        rst = 1'b1;
        set_count(1'b1, 4'd1, 1'b0);
        repeat (5) tick();
        n_checks++; if (count !== 8'd5 || tc !== 1'b0) begin
            $display("FAIL basic_up5: count=%0d tc=%b want 5/0", count, tc); n_fail++; end
        // Counting stops while en=0.
        en = 1'b0;
        repeat (2) tick();
        n_checks++; if (count !== 8'd5) begin
            $display("FAIL en_hold: got %0d want 5", count); n_fail++; end
    endtask

    task automatic test_wrap_up();
        min_val = 8'd10; max_val = 8'd20;
        drive_load(8'd18, 1'b1);
        n_checks++; if (count !== 8'd18 || ovf !== 1'b0) begin
            $display("FAIL wrap_load: count=%0d ovf=%b want 18/0", count, ovf); n_fail++; end
        set_count(1'b1, 4'd3, 1'b0);
        tick();
        n_checks++; if (count !== 8'd10 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL wrap_up: count=%0d tc=%b ovf=%b want 10/1/1", count, tc, ovf); n_fail++; end
        tick();
        n_checks++; if (count !== 8'd13 || tc !== 1'b0 || ovf !== 1'b1) begin
            $display("FAIL wrap_next: count=%0d tc=%b ovf=%b want 13/0/1", count, tc, ovf); n_fail++; end
        en = 1'b0;
    endtask

    task automatic test_sat_down();
        min_val = 8'd10; max_val = 8'd20;
        drive_load(8'd12, 1'b1);
        set_count(1'b0, 4'd4, 1'b1);
        tick();
        n_checks++; if (count !== 8'd10 || tc !== 1'b1 || udf !== 1'b1 || ovf !== 1'b0) begin
            $display("FAIL sat_down: count=%0d tc=%b udf=%b ovf=%b want 10/1/1/0", count, tc, udf, ovf);
            n_fail++; end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (count !== 8'd10 || tc !== 1'b1) begin
                $display("FAIL sat_hold[%0d]: count=%0d tc=%b want 10/1", i, count, tc); n_fail++; end
        end
        en = 1'b0;
        tick();
        n_checks++; if (tc !== 1'b0 || udf !== 1'b1) begin
            $display("FAIL sat_release: tc=%b udf=%b want 0/1", tc, udf); n_fail++; end
    endtask

    task automatic test_exact_bound();
        min_val = 8'd0; max_val = 8'd255;
        drive_load(8'd3, 1'b1);
        set_count(1'b0, 4'd3, 1'b1);
        tick();
        n_checks++; if (count !== 8'd0 || tc !== 1'b0 || udf !== 1'b0) begin
            $display("FAIL exact_min: count=%0d tc=%b udf=%b want 0/0/0", count, tc, udf); n_fail++; end
        set_count(1'b0, 4'd1, 1'b0);
        tick();
        n_checks++; if (count !== 8'd255 || tc !== 1'b1 || udf !== 1'b1) begin
            $display("FAIL under_zero: count=%0d tc=%b udf=%b want 255/1/1", count, tc, udf); n_fail++; end
        // Step to exactly max_val: 250 + 5 = 255 is not a crossing.
        drive_load(8'd250, 1'b0);
        set_count(1'b1, 4'd5, 1'b0);
        tick();
        n_checks++; if (count !== 8'd255 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL exact_max: count=%0d tc=%b ovf=%b want 255/0/0", count, tc, ovf); n_fail++; end
        // 255+15 crosses 255 in the widened compare. The counter wraps to min=0.
        set_count(1'b1, 4'd15, 1'b0);
        tick();
        n_checks++; if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL wide_wrap: count=%0d tc=%b ovf=%b want 0/1/1", count, tc, ovf); n_fail++; end
        en = 1'b0;
    endtask

    task automatic test_priority();
        // udf=1 and ovf=1 at this point. Clear both.
        drive_load(8'd0, 1'b1);
        n_checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin
            $display("FAIL clr_on_load: ovf=%b udf=%b want 0/0", ovf, udf); n_fail++; end
        // Load with en=1 and min>max applied at once. The load wins.
        min_val = 8'd20; max_val = 8'd10;
        set_count(1'b1, 4'd1, 1'b0);
        load = 1'b1; load_val = 8'hC8;
        #1;
        n_checks++; if (cfg_err !== 1'b1) begin
            $display("FAIL cfg_err: got %b want 1", cfg_err); n_fail++; end
        tick();
        load = 1'b0;
        n_checks++; if (count !== 8'hC8 || tc !== 1'b0) begin
            $display("FAIL load_prio: count=%h tc=%b want c8/0", count, tc); n_fail++; end
        tick();
        n_checks++; if (count !== 8'hC8 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL cfg_hold: count=%h tc=%b ovf=%b want c8/0/0", count, tc, ovf); n_fail++; end
        // Crossing at max=0xC8 in the same cycle as clr_flags. The set wins.
        min_val = 8'd0; max_val = 8'hC8;
        set_count(1'b1, 4'd1, 1'b1);
        clr_flags = 1'b1;
        tick();
        n_checks++; if (count !== 8'hC8 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL clr_vs_set: count=%h tc=%b ovf=%b want c8/1/1", count, tc, ovf); n_fail++; end
        en = 1'b0;
        tick();
        clr_flags = 1'b0;
        n_checks++; if (ovf !== 1'b0 || tc !== 1'b0) begin
            $display("FAIL clr_alone: ovf=%b tc=%b want 0/0", ovf, tc); n_fail++; end
    endtask

    task automatic test_out_of_range();
        min_val = 8'd10; max_val = 8'd20;
        drive_load(8'd30, 1'b1);
        n_checks++; if (count !== 8'd30) begin
            $display("FAIL load_no_clamp: got %0d want 30", count); n_fail++; end
        set_count(1'b1, 4'd1, 1'b0);
        tick();
        n_checks++; if (count !== 8'd10 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL oor_up: count=%0d tc=%b ovf=%b want 10/1/1", count, tc, ovf); n_fail++; end
        set_count(1'b1, 4'd0, 1'b0);
        tick();
        n_checks++; if (count !== 8'd10 || tc !== 1'b0) begin
            $display("FAIL step0_hold: count=%0d tc=%b want 10/0", count, tc); n_fail++; end
        // A down step from below min saturates to min.
        drive_load(8'd5, 1'b0);
        set_count(1'b0, 4'd1, 1'b1);
        tick();
        n_checks++; if (count !== 8'd10 || tc !== 1'b1 || udf !== 1'b1) begin
            $display("FAIL oor_down: count=%0d tc=%b udf=%b want 10/1/1", count, tc, udf); n_fail++; end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        // min=0 max=3 step=2 up wrap from 0 gives 2, 0(tc), 2, 0(tc).
        logic [CW-1:0] exp_cnt [4];
        logic          exp_tc  [4];
        exp_cnt = '{8'd2, 8'd0, 8'd2, 8'd0};
        exp_tc  = '{1'b0, 1'b1, 1'b0, 1'b1};
        min_val = 8'd0; max_val = 8'd3;
        drive_load(8'd0, 1'b1);
        set_count(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (count !== exp_cnt[i] || tc !== exp_tc[i]) begin
                $display("FAIL b2b[%0d]: count=%0d tc=%b want %0d/%b", i, count, tc, exp_cnt[i], exp_tc[i]);
                n_fail++; end
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; step = '0; load = 1'b0;
        load_val = '0; min_val = '0; max_val = 8'd255; sat_mode = 1'b0; clr_flags = 1'b0;
        repeat (2) tick();
        n_checks++; if (count !== 8'h00 || {tc, ovf, udf} !== 3'b000) begin
            $display("FAIL init_reset: count=%h flags=%b want 00/000", count, {tc, ovf, udf}); n_fail++; end
        rst = 1'b1;
        tick();
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_exact_bound();
        test_priority();
        test_out_of_range();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
